// File: rtl/vram_pkg.sv
// Shared VRAM geometry and arbiter state encoding.
package vram_pkg;

  localparam int unsigned VRAM_AW = 14;
  localparam int unsigned VRAM_DW = 16;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StComplete = 2'd2
  } state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Two-requester VRAM arbiter: video has priority, but the CPU is guaranteed a slot
// after MAX_VID_RUN back-to-back video grants while it is waiting.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned MAX_VID_RUN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [VRAM_DW-1:0] cpu_din,
  input  logic               cpu_ub,
  input  logic               cpu_lb,
  output logic [VRAM_DW-1:0] cpu_dout,
  output logic               cpu_ack,
  input  logic               vid_req,
  input  logic [VRAM_AW-1:0] vid_addr,
  output logic [VRAM_DW-1:0] vid_dout,
  output logic               vid_ack,
  output logic [VRAM_AW-1:0] mem_addr,
  output logic [VRAM_DW-1:0] mem_din,
  output logic               mem_we,
  output logic               mem_re,
  output logic               mem_ub,
  output logic               mem_lb,
  input  logic [VRAM_DW-1:0] mem_dout
);

  localparam int unsigned     RunW   = $clog2(MAX_VID_RUN + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_VID_RUN);

  state_e             state_q;
  logic [RunW-1:0]    vid_run_q;
  logic               win_vid_q;
  logic               cpu_ack_q, vid_ack_q;
  logic [VRAM_AW-1:0] mem_addr_q;
  logic [VRAM_DW-1:0] mem_din_q;
  logic               mem_we_q, mem_re_q, mem_ub_q, mem_lb_q;
  logic               grant_vid;

  assign grant_vid = vid_req && !(cpu_req && (vid_run_q == RunMax));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      vid_run_q  <= '0;
      win_vid_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_ub_q   <= 1'b0;
      mem_lb_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!cpu_req) vid_run_q <= '0;
          if (vid_req || cpu_req) begin
            state_q   <= StIssue;
            win_vid_q <= grant_vid;
            if (grant_vid) begin
              // A video win with the CPU waiting implies vid_run_q < RunMax.
              if (cpu_req && (vid_run_q != RunMax)) vid_run_q <= vid_run_q + 1'b1;
              mem_addr_q <= vid_addr;
              mem_din_q  <= '0;
              mem_we_q   <= 1'b0;
              mem_re_q   <= 1'b1;
              mem_ub_q   <= 1'b1;
              mem_lb_q   <= 1'b1;
            end else begin
              vid_run_q  <= '0;
              mem_addr_q <= cpu_addr;
              mem_din_q  <= cpu_din;
              mem_we_q   <= cpu_we;
              mem_re_q   <= !cpu_we;
              mem_ub_q   <= cpu_ub;
              mem_lb_q   <= cpu_lb;
            end
          end
        end
        StIssue: begin
          state_q   <= StComplete;
          mem_we_q  <= 1'b0;
          mem_re_q  <= 1'b0;
          mem_ub_q  <= 1'b0;
          mem_lb_q  <= 1'b0;
          cpu_ack_q <= !win_vid_q;
          vid_ack_q <= win_vid_q;
        end
        StComplete: begin
          state_q   <= StIdle;
          cpu_ack_q <= 1'b0;
          vid_ack_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data arrives from the VRAM during COMPLETE, so it is steered straight through.
  assign cpu_dout = cpu_ack_q ? mem_dout : '0;
  assign vid_dout = vid_ack_q ? mem_dout : '0;
  assign cpu_ack  = cpu_ack_q;
  assign vid_ack  = vid_ack_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign mem_re   = mem_re_q;
  assign mem_ub   = mem_ub_q;
  assign mem_lb   = mem_lb_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table, scoreboard and corner sequences.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ub, cpu_lb;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic [15:0] vid_dout;
  logic        vid_ack;
  logic [13:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we, mem_re, mem_ub, mem_lb;
  logic [15:0] mem_dout;

  vram_arbiter #(.MAX_VID_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ub(cpu_ub), .cpu_lb(cpu_lb), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
    .mem_ub(mem_ub), .mem_lb(mem_lb), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // VRAM model: synchronous read, byte-enabled write.
  logic [15:0] mem [0:16383];
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_ub) mem[mem_addr][15:8] <= mem_din[15:8];
      if (mem_lb) mem[mem_addr][7:0]  <= mem_din[7:0];
    end
    if (mem_re) mem_dout <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_vid;
    bit          we;
    logic [13:0] addr;
    logic [15:0] din;
    bit          ub;
    bit          lb;
    logic [15:0] dout;
  } acc_t;

  acc_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: ISSUE strobes checked against the head, popped on ack.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_ack && vid_ack) check("dual_ack", 32'(1), 32'(0));
      if (mem_we || mem_re) begin
        check("strobe_one_cycle", 32'(prev_strobe), 32'(0));
        if (sb.size() == 0) check("unexpected_access", 32'(1), 32'(0));
        else begin
          check("mem_addr", 32'(mem_addr), 32'(sb[0].addr));
          check("mem_we", 32'(mem_we), 32'(sb[0].we));
          check("mem_re", 32'(mem_re), 32'(!sb[0].we));
          check("mem_ub", 32'(mem_ub), 32'(sb[0].ub));
          check("mem_lb", 32'(mem_lb), 32'(sb[0].lb));
          if (sb[0].we) check("mem_din", 32'(mem_din), 32'(sb[0].din));
        end
      end
      if (cpu_ack || vid_ack) begin
        if (sb.size() == 0) check("unexpected_ack", 32'(1), 32'(0));
        else begin
          acc_t e;
          e = sb.pop_front();
          check("ack_winner", 32'(vid_ack), 32'(e.is_vid));
          if (!e.we) begin
            if (e.is_vid) check("vid_dout", 32'(vid_dout), 32'(e.dout));
            else          check("cpu_dout", 32'(cpu_dout), 32'(e.dout));
          end
        end
      end
    end
    prev_strobe = mem_we || mem_re;
  end

  task automatic drive(input acc_t a);
    if (a.is_vid) begin
      vid_req = 1'b1; vid_addr = a.addr;
    end else begin
      cpu_req = 1'b1; cpu_we = a.we; cpu_addr = a.addr; cpu_din = a.din;
      cpu_ub = a.ub; cpu_lb = a.lb;
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (cpu_ack || vid_ack) begin
        n = i;
        break;
      end
    end
  endtask

  acc_t vec [7];
  acc_t cpu_rd, vid_rd;
  int   n, t1;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    mem[14'h0100] = 16'hBEEF;
    mem[14'h0020] = 16'h5A5A;
    mem_dout = 16'h0;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0; cpu_ub = 0; cpu_lb = 0;
    vid_req = 0; vid_addr = '0;

    //          vid we  addr      din       ub lb dout
    vec[0] = '{0, 1, 14'h0010, 16'h1234, 1, 0, 16'h0000};
    vec[1] = '{0, 0, 14'h0010, 16'h0000, 1, 1, 16'h1200};
    vec[2] = '{1, 0, 14'h0100, 16'h0000, 1, 1, 16'hBEEF};
    vec[3] = '{0, 1, 14'h0020, 16'hFFFF, 0, 1, 16'h0000};
    vec[4] = '{0, 0, 14'h0020, 16'h0000, 1, 1, 16'h5AFF};
    vec[5] = '{0, 1, 14'h0020, 16'h0000, 0, 0, 16'h0000};
    vec[6] = '{0, 0, 14'h0020, 16'h0000, 1, 1, 16'h5AFF};
    cpu_rd = '{0, 0, 14'h0010, 16'h0000, 1, 1, 16'h1200};
    vid_rd = '{1, 0, 14'h0100, 16'h0000, 1, 1, 16'hBEEF};

    repeat (3) @(negedge clk);
    check("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    check("rst_vid_ack", 32'(vid_ack), 32'(0));
    check("rst_strobes", 32'({mem_we, mem_re, mem_ub, mem_lb}), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_din", 32'(mem_din), 32'(0));
    check("rst_douts", 32'({cpu_dout, vid_dout}), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single-requester vectors: ack must land two cycles after the grant edge.
    foreach (vec[i]) begin
      sb.push_back(vec[i]);
      drive(vec[i]);
      wait_ack(n);
      check("ack_latency", 32'(n), 32'(2));
      cpu_req = 1'b0; vid_req = 1'b0;
      @(negedge clk);
    end

    // Both held: V,V,V,V,C,V,V,V,V,C.
    for (int k = 0; k < 10; k++) sb.push_back(((k % 5) == 4) ? cpu_rd : vid_rd);
    drive(cpu_rd);
    drive(vid_rd);
    for (int k = 0; k < 10; k++) begin
      wait_ack(n);
      check("fair_spacing", 32'(n), (k == 0) ? 32'(2) : 32'(3));
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    repeat (2) @(negedge clk);

    // Request held after ack is a fresh request, acked three cycles later.
    sb.push_back(cpu_rd);
    sb.push_back(cpu_rd);
    drive(cpu_rd);
    wait_ack(n);
    check("held_first_ack", 32'(n), 32'(2));
    t1 = cyc;
    wait_ack(n);
    check("held_second_gap", 32'(cyc - t1), 32'(3));
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ISSUE of a CPU read abandons it.
    sb.push_back(vec[6]);
    drive(vec[6]);
    @(negedge clk);
    check("pre_rst_issue_re", 32'(mem_re), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    check("rst_issue_ack", 32'({cpu_ack, vid_ack}), 32'(0));
    check("rst_issue_strobes", 32'({mem_we, mem_re, mem_ub, mem_lb}), 32'(0));
    check("rst_issue_state", 32'(dut.state_q), 32'(StIdle));
    cpu_req = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_ack", 32'({cpu_ack, vid_ack}), 32'(0));
    end

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter MAX_VID_RUN, default 4: max consecutive video grants while a CPU request is pending.
REQ-002 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-005 SHALL have port cpu_we  in  1  1=write, 0=read; sampled at grant.
REQ-006 SHALL have port cpu_addr  in  14  word address [14:1].
REQ-007 SHALL have port cpu_din  in  16  write data.
REQ-008 SHALL have port cpu_ub, cpu_lb  in  1 each  byte enables for [15:8], [7:0].
REQ-009 SHALL have port cpu_dout  out  16  read data, valid while cpu_ack=1.
REQ-010 SHALL have port cpu_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have port vid_req  in  1  video fetch request, level, held until vid_ack.
REQ-012 SHALL have port vid_addr  in  14  word address.
REQ-013 SHALL have port vid_dout  out  16  fetched word, valid while vid_ack=1.
REQ-014 SHALL have port vid_ack  out  1  one-cycle completion pulse.
REQ-015 SHALL have ports mem_addr out 14, mem_din out 16, mem_we out 1, mem_re out 1, mem_ub out 1, mem_lb out 1  driving one VRAM word port.
REQ-016 SHALL have port mem_dout  in  16  VRAM read data, valid one cycle after mem_re.

Function
REQ-017 SHALL implement states IDLE, ISSUE, COMPLETE; IDLE->ISSUE when any req=1 at edge, else stay; ISSUE->COMPLETE always; COMPLETE->IDLE always.
REQ-018 SHALL choose the winner in IDLE: video if vid_req and not (cpu_req and vid_run==MAX_VID_RUN); else CPU if cpu_req.
REQ-019 SHALL register winner, address, we, data and byte enables on IDLE->ISSUE; requester inputs ignored in ISSUE/COMPLETE.
REQ-020 SHALL in ISSUE drive mem_addr/mem_din from the registered request, mem_re=!we, mem_we=we (video always read), mem_ub/mem_lb = registered enables (video: both 1).
REQ-021 SHALL in COMPLETE assert the winner's ack for exactly one cycle, with its dout = mem_dout for reads; write ack dout is don't-care.
REQ-022 SHALL hold mem_we, mem_re, mem_ub, mem_lb at 0 outside ISSUE.
REQ-023 SHALL give request-to-ack latency of 2 cycles from the grant edge; max throughput one access per 3 cycles.
REQ-024 SHALL treat a req still high in the cycle after its ack as a new request.
REQ-025 SHALL increment vid_run (saturating at MAX_VID_RUN) on each video grant while cpu_req=1; clear it on CPU grant or whenever cpu_req=0 in IDLE.
REQ-026 SHALL on simultaneous cpu_req and vid_req with vid_run<MAX_VID_RUN grant video.
REQ-027 SHALL complete a CPU write with cpu_ub=cpu_lb=0 normally: mem_we=1, both enables 0, cpu_ack pulsed.
REQ-028 SHALL never assert cpu_ack and vid_ack in the same cycle.

Reset
REQ-029 SHALL on reset=1 at an edge enter IDLE, clear vid_run, clear all acks, mem_we, mem_re, mem_ub, mem_lb and zero cpu_dout, vid_dout, mem_addr, mem_din.
REQ-030 SHALL on reset during ISSUE or COMPLETE abandon the access with no ack pulse; reset has priority over all transitions.

Structure
REQ-031 SHALL take state encoding, VRAM_AW=14 and VRAM_DW=16 from shared package vram_pkg.
REQ-032 SHALL be a single module with no sub-modules; the VRAM itself is external.

Verification
REQ-033 SHALL cover: CPU write 0x1234 to 0x0010 with ub=1, lb=0 -> ISSUE shows mem_we=1, mem_ub=1, mem_lb=0, mem_addr=0x0010; cpu_ack 2 cycles after grant.
REQ-034 SHALL cover: video read of 0x0100, mem_dout=0xBEEF in COMPLETE -> vid_ack pulse with vid_dout=0xBEEF; mem_re high exactly one cycle.
REQ-035 SHALL cover: cpu_req and vid_req both held continuously -> grant order V,V,V,V,C,V,V,V,V,C with MAX_VID_RUN=4.
REQ-036 SHALL cover: reset asserted in ISSUE of a CPU read -> no cpu_ack, all mem strobes 0 next cycle, state IDLE.
REQ-037 SHALL cover: req held high after ack -> second access granted, second ack 3 cycles after the first.
